// File: rtl/packet_router_stats.sv
// Passive statistics stage: counts completed packets on the router's two stream
// outputs and its drop path, and publishes freezable snapshots to the register bank.
module packet_router_stats #(
    parameter int CNT_WIDTH = 32,
    parameter int SATURATE  = 0
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 m0_tvalid,
    input  logic                 m0_tready,
    input  logic                 m0_tlast,
    input  logic                 m1_tvalid,
    input  logic                 m1_tready,
    input  logic                 m1_tlast,
    input  logic                 drop_tvalid,
    input  logic                 drop_tlast,
    input  logic                 stats_clear,
    input  logic                 stats_freeze,
    output logic [CNT_WIDTH-1:0] num_packets_sent_to_output_0,
    output logic [CNT_WIDTH-1:0] num_packets_sent_to_output_1,
    output logic [CNT_WIDTH-1:0] num_packets_dropped,
    output logic [2:0]           overflow,
    output logic [1:0]           in_packet
);

    localparam logic [CNT_WIDTH-1:0] ALL_ONES = '1;

    logic                 ev0, ev1, evd;
    logic                 beat0, beat1;
    logic [CNT_WIDTH-1:0] cnt0, cnt1, cntd;
    logic [CNT_WIDTH:0]   nxt0, nxt1, nxtd;
    logic [2:0]           overflow_next;

    // Result packs {overflow_this_edge, next_count}; a clear wins over any wrap.
    function automatic logic [CNT_WIDTH:0] next_count(
        input logic [CNT_WIDTH-1:0] cnt,
        input logic                 ev,
        input logic                 clr
    );
        logic [CNT_WIDTH:0] r;
        r = '0;
        if (clr) begin
            r[0] = ev;
        end else if (ev) begin
            if (cnt == ALL_ONES) begin
                r[CNT_WIDTH]     = 1'b1;
                r[CNT_WIDTH-1:0] = (SATURATE != 0) ? ALL_ONES : '0;
            end else begin
                r[CNT_WIDTH-1:0] = cnt + 1'b1;
            end
        end else begin
            r[CNT_WIDTH-1:0] = cnt;
        end
        return r;
    endfunction

    always_comb begin
        beat0 = m0_tvalid & m0_tready;
        beat1 = m1_tvalid & m1_tready;
        ev0   = beat0 & m0_tlast;
        ev1   = beat1 & m1_tlast;
        evd   = drop_tvalid & drop_tlast;
        nxt0  = next_count(cnt0, ev0, stats_clear);
        nxt1  = next_count(cnt1, ev1, stats_clear);
        nxtd  = next_count(cntd, evd, stats_clear);
        overflow_next = stats_clear ? 3'b000
                      : (overflow | {nxtd[CNT_WIDTH], nxt1[CNT_WIDTH], nxt0[CNT_WIDTH]});
    end

    // Published counts sample the pre-edge internal counters, giving two-edge latency.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt0                         <= '0;
            cnt1                         <= '0;
            cntd                         <= '0;
            overflow                     <= '0;
            in_packet                    <= '0;
            num_packets_sent_to_output_0 <= '0;
            num_packets_sent_to_output_1 <= '0;
            num_packets_dropped          <= '0;
        end else begin
            cnt0     <= nxt0[CNT_WIDTH-1:0];
            cnt1     <= nxt1[CNT_WIDTH-1:0];
            cntd     <= nxtd[CNT_WIDTH-1:0];
            overflow <= overflow_next;
            if (beat0) begin
                in_packet[0] <= ~m0_tlast;
            end
            if (beat1) begin
                in_packet[1] <= ~m1_tlast;
            end
            if (!stats_freeze) begin
                num_packets_sent_to_output_0 <= cnt0;
                num_packets_sent_to_output_1 <= cnt1;
                num_packets_dropped          <= cntd;
            end
        end
    end

endmodule

// File: tb/tb_packet_router_stats.sv
// Directed bench for packet_router_stats: a vector table for the basic counting
// and clear behaviour, plus sequences for wrap, saturation, freeze and mid-packet reset.
module tb_packet_router_stats;

    logic        clk = 1'b0;
    logic        resetn;
    logic        m0_tvalid, m0_tready, m0_tlast;
    logic        m1_tvalid, m1_tready, m1_tlast;
    logic        drop_tvalid, drop_tlast;
    logic        stats_clear, stats_freeze;
    logic [31:0] out0, out1, outd;
    logic [2:0]  ovf;
    logic [1:0]  inp;
    logic [3:0]  w_out0, w_out1, w_outd;
    logic [2:0]  w_ovf;
    logic [1:0]  w_inp;
    logic [3:0]  s_out0, s_out1, s_outd;
    logic [2:0]  s_ovf;
    logic [1:0]  s_inp;

    int total = 0;
    int bad   = 0;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    typedef struct {
        logic m0v, m0r, m0l, m1v, m1r, m1l, dv, dl, clr, frz;
        logic [31:0] e0, e1, ed;
        logic [2:0]  eovf;
        logic [1:0]  einp;
    } vec_t;

    vec_t vecs[17];

    always #5 clk = ~clk;

    packet_router_stats dut (
        .clk(clk), .resetn(resetn),
        .m0_tvalid(m0_tvalid), .m0_tready(m0_tready), .m0_tlast(m0_tlast),
        .m1_tvalid(m1_tvalid), .m1_tready(m1_tready), .m1_tlast(m1_tlast),
        .drop_tvalid(drop_tvalid), .drop_tlast(drop_tlast),
        .stats_clear(stats_clear), .stats_freeze(stats_freeze),
        .num_packets_sent_to_output_0(out0), .num_packets_sent_to_output_1(out1),
        .num_packets_dropped(outd), .overflow(ovf), .in_packet(inp)
    );

    packet_router_stats #(.CNT_WIDTH(4), .SATURATE(0)) dut_wrap (
        .clk(clk), .resetn(resetn),
        .m0_tvalid(m0_tvalid), .m0_tready(m0_tready), .m0_tlast(m0_tlast),
        .m1_tvalid(m1_tvalid), .m1_tready(m1_tready), .m1_tlast(m1_tlast),
        .drop_tvalid(drop_tvalid), .drop_tlast(drop_tlast),
        .stats_clear(stats_clear), .stats_freeze(stats_freeze),
        .num_packets_sent_to_output_0(w_out0), .num_packets_sent_to_output_1(w_out1),
        .num_packets_dropped(w_outd), .overflow(w_ovf), .in_packet(w_inp)
    );

    packet_router_stats #(.CNT_WIDTH(4), .SATURATE(1)) dut_sat (
        .clk(clk), .resetn(resetn),
        .m0_tvalid(m0_tvalid), .m0_tready(m0_tready), .m0_tlast(m0_tlast),
        .m1_tvalid(m1_tvalid), .m1_tready(m1_tready), .m1_tlast(m1_tlast),
        .drop_tvalid(drop_tvalid), .drop_tlast(drop_tlast),
        .stats_clear(stats_clear), .stats_freeze(stats_freeze),
        .num_packets_sent_to_output_0(s_out0), .num_packets_sent_to_output_1(s_out1),
        .num_packets_dropped(s_outd), .overflow(s_ovf), .in_packet(s_inp)
    );

    // Inputs change and outputs are sampled on the falling edge, half a period from the active edge.
    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        m0_tvalid    = v.m0v;
        m0_tready    = v.m0r;
        m0_tlast     = v.m0l;
        m1_tvalid    = v.m1v;
        m1_tready    = v.m1r;
        m1_tlast     = v.m1l;
        drop_tvalid  = v.dv;
        drop_tlast   = v.dl;
        stats_clear  = v.clr;
        stats_freeze = v.frz;
    endtask

    // Single-beat packets on the selected paths for one edge.
    task automatic events(input logic e0, input logic e1, input logic ed, input logic clr);
        m0_tvalid   = e0; m0_tready = e0; m0_tlast = e0;
        m1_tvalid   = e1; m1_tready = e1; m1_tlast = e1;
        drop_tvalid = ed; drop_tlast = ed;
        stats_clear = clr;
        cycle();
        m0_tvalid   = 1'b0; m0_tready = 1'b0; m0_tlast = 1'b0;
        m1_tvalid   = 1'b0; m1_tready = 1'b0; m1_tlast = 1'b0;
        drop_tvalid = 1'b0; drop_tlast = 1'b0;
        stats_clear = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) events(L, L, L, L);
    endtask

    task automatic doReset();
        resetn = 1'b0;
        idle(1);
        resetn = 1'b1;
    endtask

    task automatic checkCounts(input string name, input logic [31:0] e0, input logic [31:0] e1,
                               input logic [31:0] ed);
        checkOutput({name, "_out0"}, out0, e0);
        checkOutput({name, "_out1"}, out1, e1);
        checkOutput({name, "_drop"}, outd, ed);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int beats;
        logic rdy;
        logic exp_inp;

        // m0v m0r m0l  m1v m1r m1l  dv dl  clr frz | out0 out1 drop ovf inp
        vecs[0]  = '{H,H,L, L,L,L, L,L, L,L, 32'd0, 32'd0, 32'd0, 3'b000, 2'b01};
        vecs[1]  = '{H,L,H, L,L,L, L,L, L,L, 32'd0, 32'd0, 32'd0, 3'b000, 2'b01};
        vecs[2]  = '{H,H,H, L,L,L, L,L, L,L, 32'd0, 32'd0, 32'd0, 3'b000, 2'b00};
        vecs[3]  = '{L,L,L, L,L,L, L,L, L,L, 32'd1, 32'd0, 32'd0, 3'b000, 2'b00};
        vecs[4]  = '{L,L,L, H,H,L, H,L, L,L, 32'd1, 32'd0, 32'd0, 3'b000, 2'b10};
        vecs[5]  = '{H,H,H, H,H,H, H,H, L,L, 32'd1, 32'd0, 32'd0, 3'b000, 2'b00};
        vecs[6]  = '{H,H,H, H,H,H, H,H, L,L, 32'd2, 32'd1, 32'd1, 3'b000, 2'b00};
        vecs[7]  = '{L,L,L, L,L,L, L,L, L,L, 32'd3, 32'd2, 32'd2, 3'b000, 2'b00};
        vecs[8]  = '{L,H,H, H,L,H, L,L, L,L, 32'd3, 32'd2, 32'd2, 3'b000, 2'b00};
        vecs[9]  = '{L,L,L, L,L,L, L,H, L,L, 32'd3, 32'd2, 32'd2, 3'b000, 2'b00};
        vecs[10] = '{H,H,H, H,H,H, H,H, H,L, 32'd3, 32'd2, 32'd2, 3'b000, 2'b00};
        vecs[11] = '{H,H,H, H,H,H, H,H, L,L, 32'd1, 32'd1, 32'd1, 3'b000, 2'b00};
        vecs[12] = '{H,H,H, H,H,H, H,H, L,L, 32'd2, 32'd2, 32'd2, 3'b000, 2'b00};
        vecs[13] = '{H,H,H, H,H,H, H,H, L,L, 32'd3, 32'd3, 32'd3, 3'b000, 2'b00};
        vecs[14] = '{H,H,H, H,H,H, H,H, L,L, 32'd4, 32'd4, 32'd4, 3'b000, 2'b00};
        vecs[15] = '{L,L,L, L,L,L, L,L, L,L, 32'd5, 32'd5, 32'd5, 3'b000, 2'b00};
        vecs[16] = '{L,L,L, L,L,L, L,L, L,L, 32'd5, 32'd5, 32'd5, 3'b000, 2'b00};

        resetn = 1'b0;
        stats_freeze = 1'b0;
        events(L, L, L, L);
        idle(1);
        checkCounts("reset", 32'd0, 32'd0, 32'd0);
        checkOutput("reset_ovf", {29'd0, ovf}, 32'd0);
        checkOutput("reset_inp", {30'd0, inp}, 32'd0);
        resetn = 1'b1;

        for (int i = 0; i < 17; i++) begin
            applyStimulus(vecs[i]);
            cycle();
            checkOutput($sformatf("vec%0d_out0", i), out0, vecs[i].e0);
            checkOutput($sformatf("vec%0d_out1", i), out1, vecs[i].e1);
            checkOutput($sformatf("vec%0d_drop", i), outd, vecs[i].ed);
            checkOutput($sformatf("vec%0d_ovf", i), {29'd0, ovf}, {29'd0, vecs[i].eovf});
            checkOutput($sformatf("vec%0d_inp", i), {30'd0, inp}, {30'd0, vecs[i].einp});
        end
        applyStimulus('{L,L,L, L,L,L, L,L, L,L, 32'd0, 32'd0, 32'd0, 3'b000, 2'b00});

        // Three 4-beat packets on output 0 with tready toggling every cycle.
        doReset();
        beats = 0;
        rdy = 1'b1;
        exp_inp = 1'b0;
        for (int c = 0; c < 100 && beats < 12; c++) begin
            m0_tvalid = 1'b1;
            m0_tready = rdy;
            m0_tlast  = (beats % 4 == 3);
            cycle();
            if (rdy) begin
                exp_inp = (beats % 4 != 3);
                beats++;
            end
            checkOutput($sformatf("toggle_c%0d_inp0", c), {31'd0, inp[0]}, {31'd0, exp_inp});
            rdy = ~rdy;
        end
        checkOutput("toggle_beats", beats, 32'd12);
        idle(2);
        checkCounts("toggle", 32'd3, 32'd0, 32'd0);

        // 17 packets on output 1 into 4-bit counters: wrap to 1 vs saturate at 15.
        doReset();
        for (int k = 0; k < 17; k++) events(L, H, L, L);
        idle(2);
        checkOutput("wrap_out1", {28'd0, w_out1}, 32'd1);
        checkOutput("wrap_ovf", {29'd0, w_ovf}, 32'd2);
        checkOutput("sat_out1", {28'd0, s_out1}, 32'd15);
        checkOutput("sat_ovf", {29'd0, s_ovf}, 32'd2);
        checkOutput("wide_out1", out1, 32'd17);
        checkOutput("wide_ovf", {29'd0, ovf}, 32'd0);

        // Clear coinciding with an output-0 packet, from a published count of 9.
        for (int k = 0; k < 9; k++) events(H, L, L, L);
        idle(2);
        checkOutput("preclr_out0", out0, 32'd9);
        events(H, L, L, H);
        checkOutput("clr_wrap_ovf", {29'd0, w_ovf}, 32'd0);
        checkOutput("clr_sat_ovf", {29'd0, s_ovf}, 32'd0);
        idle(2);
        checkCounts("clr", 32'd1, 32'd0, 32'd0);
        checkOutput("clr_wrap_out0", {28'd0, w_out0}, 32'd1);
        checkOutput("clr_sat_out1", {28'd0, s_out1}, 32'd0);

        // Freeze holds 7/2/4 while clearing and counting continue underneath.
        doReset();
        for (int k = 0; k < 7; k++) events(H, logic'(k < 2), logic'(k < 4), L);
        idle(2);
        checkCounts("prefrz", 32'd7, 32'd2, 32'd4);
        stats_freeze = 1'b1;
        events(L, L, L, H);
        checkCounts("frz_clr", 32'd7, 32'd2, 32'd4);
        events(H, L, L, L);
        events(H, L, L, L);
        idle(1);
        checkCounts("frz_hold", 32'd7, 32'd2, 32'd4);
        stats_freeze = 1'b0;
        idle(2);
        checkCounts("unfrz", 32'd2, 32'd0, 32'd0);

        // One-cycle reset in the middle of an output-0 packet.
        m0_tvalid = 1'b1; m0_tready = 1'b1; m0_tlast = 1'b0;
        cycle();
        checkOutput("midrst_pre_inp", {30'd0, inp}, 32'd1);
        doReset();
        checkCounts("midrst", 32'd0, 32'd0, 32'd0);
        checkOutput("midrst_inp", {30'd0, inp}, 32'd0);
        m0_tvalid = 1'b1; m0_tready = 1'b1; m0_tlast = 1'b0;
        cycle();
        checkOutput("midrst_beat_inp", {30'd0, inp}, 32'd1);
        events(H, L, L, L);
        checkOutput("midrst_last_inp", {30'd0, inp}, 32'd0);
        idle(2);
        checkCounts("midrst_done", 32'd1, 32'd0, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/packet_router_stats.md
Name: packet_router_stats

Overview:
- Statistics counter stage that sits directly upstream of the AXI-Lite register bank.
- Snoops the router's two AXI-Stream output ports and its drop path, and counts completed packets per destination and dropped packets.
- Presents three coherent counter values, plus sticky overflow flags, to the register bank.
- Passive observer: never drives or back-pressures the data path.

Parameters:
CNT_WIDTH, 32, width of each packet counter and each published count
SATURATE, 0, 0 = counters wrap to 0 on overflow; 1 = counters hold at all-ones on overflow

Ports:
clk  input  1  system clock, all logic on rising edge
resetn  input  1  synchronous active-low reset
m0_tvalid  input  1  output 0 stream valid (snooped)
m0_tready  input  1  output 0 stream ready (snooped)
m0_tlast  input  1  output 0 end-of-packet beat (snooped)
m1_tvalid  input  1  output 1 stream valid (snooped)
m1_tready  input  1  output 1 stream ready (snooped)
m1_tlast  input  1  output 1 end-of-packet beat (snooped)
drop_tvalid  input  1  beat consumed by the router's discard path
drop_tlast  input  1  last beat of a discarded packet
stats_clear  input  1  single-cycle pulse; zeroes counters and overflow flags
stats_freeze  input  1  level; holds published counts stable while high
num_packets_sent_to_output_0  output  CNT_WIDTH  published output 0 packet count
num_packets_sent_to_output_1  output  CNT_WIDTH  published output 1 packet count
num_packets_dropped  output  CNT_WIDTH  published dropped packet count
overflow  output  3  sticky overflow flags: [0] out0, [1] out1, [2] dropped
in_packet  output  2  per output: 1 while a packet is mid-transfer

Behaviour:
- Reset is synchronous, sampled on clk rise with resetn=0. It zeroes all internal counters, all published counts, overflow and in_packet.
- Resetting mid-packet discards the partial packet: the next tlast beat after reset counts as one packet.
- Events are sampled at the clk rise:
  - ev0 = m0_tvalid & m0_tready & m0_tlast
  - ev1 = m1_tvalid & m1_tready & m1_tlast
  - evd = drop_tvalid & drop_tlast (no ready on the drop path)
- Beats without tlast never change any counter.
- Each event increments its internal counter by exactly 1. The three events are independent, so all three may fire in the same cycle.
- Overflow when the internal counter equals all-ones and its event fires:
  - SATURATE=0: the counter becomes 0.
  - SATURATE=1: the counter stays at all-ones.
  - In both modes the matching overflow bit sets in that same edge and stays set until stats_clear or reset.
- stats_clear at edge N:
  - Each internal counter loads 1 if its event fires at N, otherwise 0.
  - All overflow bits clear; an overflow coinciding with the clear is not flagged.
  - in_packet is not affected.
- Publishing:
  - The published outputs are registers loaded from the internal counters on every edge where stats_freeze=0.
  - An event at edge N is visible on the outputs after edge N+1 (two-edge latency) when freeze is low.
  - While stats_freeze=1 the published outputs hold their values; internal counting and clearing continue unaffected.
  - On freeze release at edge M, the outputs reflect the internal counters after edge M+1.
  - overflow and in_packet are never frozen.
- in_packet[i]:
  - Set at an accepted beat (tvalid&tready) with tlast=0.
  - Cleared at an accepted beat with tlast=1.
  - Unchanged when there is no handshake.
- tvalid held without tready counts nothing; a stalled last beat counts once, at acceptance.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset, then send 3 packets of 4 beats on output 0, with tready toggling every cycle -> num_packets_sent_to_output_0=3, out1=0, dropped=0; in_packet[0] is 1 during beats 1-3 of each packet.
- Fire ev0, ev1 and evd in the same cycle, 5 times -> all three counts =5, overflow=3'b000.
- CNT_WIDTH=4, SATURATE=0, 17 packets on output 1 -> count=1, overflow[1]=1. With SATURATE=1 -> count=15, overflow[1]=1.
- Counts at 7/2/4; raise stats_freeze, send 2 out0 packets and pulse stats_clear -> outputs hold 7/2/4 while frozen. After release plus 2 edges -> 2/0/0.
- stats_clear in the same cycle as ev0, with out0 previously at 9 -> out0 publishes 1; overflow is cleared.
- Assert resetn=0 for one cycle mid-packet on output 0, then finish the packet with 2 beats ending in tlast -> outputs 0 during reset, then out0=1; in_packet[0]=0 immediately after reset.
